ifetch: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline. Sits between the PC register and decode. It takes the current `pc` and computes `npc` to feed back into the PC register, which has no enable. It also drives a req/ready instruction-memory port and owns the IF/ID pipeline register. Stall, branch/jump redirect and variable-latency memory responses are all resolved here, so no other stage ever sees a wrong-path instruction.

---
 rtl/ifetch_if.sv | 11 +
 rtl/ifetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Instruction-memory request/response port between the fetch stage and imem.
// The fetch stage drives req/addr; memory answers with ready/rdata.
interface ifetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifetch.sv
// Instruction-fetch stage: computes npc, drives the imem port and owns IF/ID.
// Stall, redirect and variable memory latency are resolved here.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     pc,
   output logic [31:0]     npc,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [31:0]     redirect_pc,
   ifetch_if.master        imem,
   output logic            ifid_valid,
   output logic [31:0]     ifid_pc,
   output logic [31:0]     ifid_inst,
   output logic [31:0]     ifid_pc4
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_KILL = 2'd2,
      S_FULL = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  buf_q, buf_d;
   logic             ifid_valid_q, ifid_valid_d;
   logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0]  ifid_inst_q, ifid_inst_d;
   logic [XLEN-1:0]  ifid_pc4_q, ifid_pc4_d;

   logic             stalled;
   logic             req;
   logic             fire;
   logic             deliver;
   logic [XLEN-1:0]  del_pc;
   logic [XLEN-1:0]  del_inst;
   logic             unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Request generation: IF/ID "occupied" means a valid entry decode refuses to take.
   always_comb begin
      stalled = stall && ifid_valid_q;
      req     = 1'b0;
      if (!reset) begin
         case (state_q)
            S_BUSY, S_KILL: req = 1'b1;
            S_IDLE:         req = !redirect_valid && !stalled;
            default:        req = 1'b0;
         endcase
      end
      fire = req && imem.imem_ready;
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = (state_q == S_IDLE) ? pc : addr_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; redirect takes precedence over normal progress
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         case (state_q)
            S_BUSY:  state_d = imem.imem_ready ? S_IDLE : S_KILL;
            S_KILL:  state_d = imem.imem_ready ? S_IDLE : S_KILL;
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE:  if (req && !imem.imem_ready) state_d = S_BUSY;
            S_BUSY:  if (imem.imem_ready) state_d = stalled ? S_FULL : S_IDLE;
            S_FULL:  if (!stalled) state_d = S_IDLE;
            S_KILL:  if (imem.imem_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic: npc, deliver selection, address latch and skid buffer
   always_comb begin
      npc      = pc;
      deliver  = 1'b0;
      del_pc   = addr_q;
      del_inst = imem.imem_rdata;
      addr_d   = addr_q;
      buf_d    = buf_q;
      if (reset) begin
         npc = RESET_PC;
      end else if (redirect_valid) begin
         npc = {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fire) begin
                  deliver = 1'b1;
                  del_pc  = pc;
               end else if (req) begin
                  addr_d = pc;
               end
            end
            S_BUSY: begin
               if (imem.imem_ready && !stalled) deliver = 1'b1;
               else if (imem.imem_ready)        buf_d   = imem.imem_rdata;
            end
            S_FULL: begin
               if (!stalled) begin
                  deliver  = 1'b1;
                  del_inst = buf_q;
               end
            end
            default: ;
         endcase
         if (deliver) npc = pc + PC_STEP;
      end
   end

   // IF/ID next value: flush on redirect, load on deliver, bubble when free
   always_comb begin
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pc4_d   = ifid_pc4_q;
      if (redirect_valid) begin
         ifid_valid_d = 1'b0;
         ifid_inst_d  = NOP_INST;
      end else if (deliver) begin
         ifid_valid_d = 1'b1;
         ifid_pc_d    = del_pc;
         ifid_inst_d  = del_inst;
         ifid_pc4_d   = del_pc + PC_STEP;
      end else if (!stalled) begin
         ifid_valid_d = 1'b0;
         ifid_inst_d  = NOP_INST;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q       <= '0;
         buf_q        <= '0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_inst_q  <= NOP_INST;
         ifid_pc4_q   <= '0;
      end else begin
         addr_q       <= addr_d;
         buf_q        <= buf_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_pc4_q   <= ifid_pc4_d;
      end
   end

   assign ifid_valid = ifid_valid_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_inst  = ifid_inst_q;
   assign ifid_pc4   = ifid_pc4_q;

endmodule
